// File: rtl/i2c_txn_sequencer_if.sv
// Bundled handshake/bus signals between the I2C transaction sequencer and its environment
// (control registers, write FIFO, byte engine, readback FIFO).
interface i2c_txn_sequencer_if;
  logic       i2c_start;
  logic       i2c_reset;
  logic       i2c_clr_start;
  logic [7:0] wf_data;
  logic       wf_empty;
  logic       wf_rden;
  logic [1:0] bus_sel;
  logic       eng_go;
  logic [1:0] eng_cmd;
  logic [7:0] eng_tx;
  logic       eng_mack;
  logic       eng_abort;
  logic       eng_done;
  logic       eng_nack;
  logic [7:0] eng_rx;
  logic [7:0] rb_data;
  logic       rb_we;
  logic       rb_full;
  logic [7:0] i2c_status;

  modport master (
    input  i2c_start, i2c_reset, wf_data, wf_empty, eng_done, eng_nack, eng_rx, rb_full,
    output i2c_clr_start, wf_rden, bus_sel, eng_go, eng_cmd, eng_tx, eng_mack, eng_abort,
           rb_data, rb_we, i2c_status
  );

  modport slave (
    output i2c_start, i2c_reset, wf_data, wf_empty, eng_done, eng_nack, eng_rx, rb_full,
    input  i2c_clr_start, wf_rden, bus_sel, eng_go, eng_cmd, eng_tx, eng_mack, eng_abort,
           rb_data, rb_we, i2c_status
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Parses descriptors from the write FIFO and drives one shared I2C byte engine across
// the DAQ/TRG/NVIO links, pushing read bytes to the readback FIFO.
module i2c_txn_sequencer (
  input  logic                       clk40_i,
  input  logic                       rst_i,
  i2c_txn_sequencer_if.master        bus
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_ADDR, S_LEN, S_START, S_SADDR, S_WR, S_RD, S_RBW, S_STOP, S_FLUSH
  } state_t;

  state_t     state_q;
  logic       start_q;
  logic       clr_start_q;
  logic       wf_rden_q;
  logic [1:0] bus_sel_q;
  logic       eng_go_q;
  logic [1:0] eng_cmd_q;
  logic [7:0] eng_tx_q;
  logic       eng_mack_q;
  logic       eng_abort_q;
  logic       pend_q;
  logic [7:0] addr_q;
  logic [7:0] cnt_q;
  logic [7:0] rb_data_q;
  logic       rb_we_q;
  logic       busy_q;
  logic       done_q;
  logic       nack_q;
  logic       under_q;
  logic       bad_q;
  logic [1:0] stat_bus_q;

  logic start_rise;
  assign start_rise = bus.i2c_start & ~start_q;

  always_ff @(posedge clk40_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      clr_start_q <= 1'b0;
      wf_rden_q   <= 1'b0;
      bus_sel_q   <= 2'd0;
      eng_go_q    <= 1'b0;
      eng_cmd_q   <= CMD_START;
      eng_tx_q    <= 8'h00;
      eng_mack_q  <= 1'b0;
      eng_abort_q <= 1'b0;
      pend_q      <= 1'b0;
      addr_q      <= 8'h00;
      cnt_q       <= 8'h00;
      rb_data_q   <= 8'h00;
      rb_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      under_q     <= 1'b0;
      bad_q       <= 1'b0;
      stat_bus_q  <= 2'd0;
    end else begin
      start_q     <= bus.i2c_start;
      clr_start_q <= 1'b0;
      wf_rden_q   <= 1'b0;
      eng_go_q    <= 1'b0;
      eng_abort_q <= 1'b0;
      rb_we_q     <= 1'b0;

      if (bus.i2c_reset) begin
        // Soft abort wins over everything, including a coincident ENG_DONE.
        state_q     <= S_IDLE;
        eng_abort_q <= pend_q;
        pend_q      <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        nack_q      <= 1'b0;
        under_q     <= 1'b0;
        bad_q       <= 1'b0;
        stat_bus_q  <= 2'd0;
      end else begin
        // A pop in flight leaves a stale head/empty for one cycle, so FIFO-reading
        // states wait while wf_rden_q is high.
        case (state_q)
          S_IDLE: begin
            if (start_rise) begin
              clr_start_q <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              nack_q      <= 1'b0;
              under_q     <= 1'b0;
              bad_q       <= 1'b0;
              state_q     <= S_HDR;
            end
          end
          S_HDR: begin
            if (!wf_rden_q) begin
              if (bus.wf_empty) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                wf_rden_q  <= 1'b1;
                bus_sel_q  <= bus.wf_data[1:0];
                stat_bus_q <= bus.wf_data[1:0];
                if (bus.wf_data[1:0] == 2'd3) begin
                  bad_q   <= 1'b1;
                  state_q <= S_FLUSH;
                end else begin
                  state_q <= S_ADDR;
                end
              end
            end
          end
          S_ADDR, S_LEN: begin
            if (!wf_rden_q) begin
              if (bus.wf_empty) begin
                under_q <= 1'b1;
                state_q <= S_FLUSH;
              end else begin
                wf_rden_q <= 1'b1;
                if (state_q == S_ADDR) begin
                  addr_q  <= bus.wf_data;
                  state_q <= S_LEN;
                end else begin
                  cnt_q   <= bus.wf_data;
                  state_q <= S_START;
                end
              end
            end
          end
          S_START: begin
            if (!pend_q) begin
              eng_go_q   <= 1'b1;
              eng_cmd_q  <= CMD_START;
              eng_mack_q <= 1'b0;
              pend_q     <= 1'b1;
            end else if (bus.eng_done) begin
              pend_q  <= 1'b0;
              state_q <= S_SADDR;
            end
          end
          S_SADDR: begin
            if (!pend_q) begin
              eng_go_q   <= 1'b1;
              eng_cmd_q  <= CMD_WRITE;
              eng_tx_q   <= addr_q;
              eng_mack_q <= 1'b0;
              pend_q     <= 1'b1;
            end else if (bus.eng_done) begin
              pend_q <= 1'b0;
              if (bus.eng_nack) begin
                nack_q  <= 1'b1;
                state_q <= S_STOP;
              end else if (cnt_q == 8'd0) begin
                state_q <= S_STOP;
              end else if (addr_q[0]) begin
                state_q <= S_RD;
              end else begin
                state_q <= S_WR;
              end
            end
          end
          S_WR: begin
            if (!pend_q) begin
              if (!wf_rden_q) begin
                if (bus.wf_empty) begin
                  under_q <= 1'b1;
                  state_q <= S_STOP;
                end else begin
                  wf_rden_q  <= 1'b1;
                  eng_go_q   <= 1'b1;
                  eng_cmd_q  <= CMD_WRITE;
                  eng_tx_q   <= bus.wf_data;
                  eng_mack_q <= 1'b0;
                  pend_q     <= 1'b1;
                end
              end
            end else if (bus.eng_done) begin
              pend_q <= 1'b0;
              cnt_q  <= cnt_q - 8'd1;
              if (bus.eng_nack) begin
                nack_q  <= 1'b1;
                state_q <= S_STOP;
              end else if (cnt_q == 8'd1) begin
                state_q <= S_STOP;
              end
            end
          end
          S_RD: begin
            if (!pend_q) begin
              if (!bus.rb_full) begin
                eng_go_q   <= 1'b1;
                eng_cmd_q  <= CMD_READ;
                eng_mack_q <= (cnt_q != 8'd1);
                pend_q     <= 1'b1;
              end
            end else if (bus.eng_done) begin
              pend_q    <= 1'b0;
              rb_data_q <= bus.eng_rx;
              rb_we_q   <= 1'b1;
              state_q   <= S_RBW;
            end
          end
          S_RBW: begin
            cnt_q   <= cnt_q - 8'd1;
            state_q <= (cnt_q == 8'd1) ? S_STOP : S_RD;
          end
          S_STOP: begin
            if (!pend_q) begin
              eng_go_q   <= 1'b1;
              eng_cmd_q  <= CMD_STOP;
              eng_mack_q <= 1'b0;
              pend_q     <= 1'b1;
            end else if (bus.eng_done) begin
              pend_q  <= 1'b0;
              state_q <= (nack_q || under_q) ? S_FLUSH : S_HDR;
            end
          end
          S_FLUSH: begin
            if (!wf_rden_q) begin
              if (bus.wf_empty) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                wf_rden_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.i2c_clr_start = clr_start_q;
  assign bus.wf_rden       = wf_rden_q;
  assign bus.bus_sel       = bus_sel_q;
  assign bus.eng_go        = eng_go_q;
  assign bus.eng_cmd       = eng_cmd_q;
  assign bus.eng_tx        = eng_tx_q;
  assign bus.eng_mack      = eng_mack_q;
  assign bus.eng_abort     = eng_abort_q;
  assign bus.rb_data       = rb_data_q;
  assign bus.rb_we         = rb_we_q;
  assign bus.i2c_status    = {stat_bus_q, 1'b0, bad_q, under_q, nack_q, done_q, busy_q};

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: FIFO and engine models, a descriptor-level reference model,
// and a per-cycle monitor comparing engine commands and readback pushes against it.
module tb_i2c_txn_sequencer;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] tx;
    logic       mack;
  } ecmd_t;

  logic clk40 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk40 = ~clk40;

  i2c_txn_sequencer_if bus();
  i2c_txn_sequencer dut (.clk40_i(clk40), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0] wf_q[$];
  logic [7:0] m_q[$];
  logic [7:0] rx_list[$];
  logic [7:0] rx_eng[$];
  logic [7:0] exp_rb[$];
  ecmd_t      exp_cmd[$];

  int         lat = 2;
  bit         nack_en = 1'b0;
  logic [7:0] nack_byte = 8'h00;
  logic [1:0] m_bus = 2'd0;
  logic [7:0] m_status;
  int         clr_cnt = 0;
  int         abort_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within its cycle budget", name);
  endtask

  task automatic push_cmd(input logic [1:0] c, input logic [7:0] t, input logic m);
    ecmd_t e;
    e.cmd = c; e.tx = t; e.mack = m;
    exp_cmd.push_back(e);
  endtask

  // Reference: walk the descriptor bytes in m_q and list the commands, readback
  // bytes and final status a correct sequencer must produce.
  task automatic run_model();
    logic [7:0] hdr, addr, len, b;
    bit nk, ur, bd, err;
    int rxi;
    nk = 0; ur = 0; bd = 0; err = 0; rxi = 0;
    while (!err && m_q.size() > 0) begin
      hdr   = m_q.pop_front();
      m_bus = hdr[1:0];
      if (m_bus == 2'd3) begin
        bd = 1; err = 1;
      end else if (m_q.size() < 2) begin
        ur = 1; err = 1;
      end else begin
        addr = m_q.pop_front();
        len  = m_q.pop_front();
        push_cmd(C_START, 8'h00, 1'b0);
        push_cmd(C_WRITE, addr, 1'b0);
        if (nack_en && addr == nack_byte) begin
          nk = 1;
        end else if (addr[0]) begin
          for (int i = 0; i < int'(len); i++) begin
            push_cmd(C_READ, 8'h00, (i != int'(len) - 1));
            exp_rb.push_back(rx_list[rxi]);
            rxi++;
          end
        end else begin
          for (int i = 0; i < int'(len) && !nk && !ur; i++) begin
            if (m_q.size() == 0) ur = 1;
            else begin
              b = m_q.pop_front();
              push_cmd(C_WRITE, b, 1'b0);
              if (nack_en && b == nack_byte) nk = 1;
            end
          end
        end
        push_cmd(C_STOP, 8'h00, 1'b0);
        err = nk | ur;
      end
    end
    m_q.delete();
    m_status = {m_bus, 1'b0, bd, ur, nk, 1'b1, 1'b0};
  endtask

  // First-word-fall-through write FIFO: pops at the edge where wf_rden was high.
  initial begin
    bit p;
    bus.wf_data  = 8'h00;
    bus.wf_empty = 1'b1;
    forever begin
      @(negedge clk40);
      p = bus.wf_rden;
      @(posedge clk40);
      #1;
      if (p && wf_q.size() > 0) void'(wf_q.pop_front());
      bus.wf_empty = (wf_q.size() == 0);
      bus.wf_data  = (wf_q.size() > 0) ? wf_q[0] : 8'h00;
    end
  end

  // Byte engine: answers each ENG_GO after `lat` cycles unless aborted.
  initial begin
    logic [1:0] c;
    logic [7:0] t;
    bit ab;
    bus.eng_done = 1'b0;
    bus.eng_nack = 1'b0;
    bus.eng_rx   = 8'h00;
    forever begin
      @(negedge clk40);
      if (bus.eng_go === 1'b1) begin
        c  = bus.eng_cmd;
        t  = bus.eng_tx;
        ab = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk40);
          if (bus.eng_abort || rst) begin
            ab = 1'b1;
            break;
          end
        end
        if (!ab) begin
          bus.eng_done = 1'b1;
          bus.eng_nack = (c == C_WRITE) && nack_en && (t == nack_byte);
          bus.eng_rx   = 8'h00;
          if (c == C_READ && rx_eng.size() > 0) bus.eng_rx = rx_eng.pop_front();
          @(negedge clk40);
          bus.eng_done = 1'b0;
          bus.eng_nack = 1'b0;
        end
      end
    end
  end

  // Monitor: sampled 2 time units after each rising edge.
  initial begin
    bit outstanding;
    logic [10:0] held;
    ecmd_t e;
    outstanding = 1'b0;
    held = '0;
    forever begin
      @(posedge clk40);
      #2;
      if (rst) begin
        outstanding = 1'b0;
      end else begin
        if (bus.eng_abort) begin
          abort_cnt++;
          outstanding = 1'b0;
        end
        if (bus.eng_done) outstanding = 1'b0;
        if (bus.i2c_clr_start) clr_cnt++;
        if (bus.rb_we) begin
          if (exp_rb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rb_we: got data 0x%0h, expected no push", bus.rb_data);
          end else begin
            chk("rb_data", bus.rb_data, exp_rb.pop_front());
          end
        end
        if (bus.eng_go) begin
          chk("go_while_outstanding", outstanding, 0);
          if (exp_cmd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_go: got cmd %0d tx 0x%0h, expected no command",
                     bus.eng_cmd, bus.eng_tx);
          end else begin
            e = exp_cmd.pop_front();
            chk("eng_cmd", bus.eng_cmd, e.cmd);
            if (e.cmd == C_WRITE) chk("eng_tx", bus.eng_tx, e.tx);
            if (e.cmd == C_READ) begin
              chk("eng_mack", bus.eng_mack, e.mack);
              chk("read_while_rb_full", bus.rb_full, 0);
            end
          end
          outstanding = 1'b1;
          held = {bus.eng_cmd, bus.eng_tx, bus.eng_mack};
        end else if (outstanding) begin
          chk("cmd_stable", {bus.eng_cmd, bus.eng_tx, bus.eng_mack}, held);
        end
      end
    end
  end

  task automatic run_txn(input string name, input logic [7:0] lit_status);
    int n;
    m_q = wf_q;
    rx_eng = rx_list;
    exp_cmd.delete();
    exp_rb.delete();
    run_model();
    chk({name, "_model_status"}, m_status, lit_status);
    repeat (3) @(negedge clk40);
    clr_cnt = 0;
    abort_cnt = 0;
    bus.i2c_start = 1'b1;
    n = 0;
    while (!(clr_cnt > 0 && bus.i2c_status[1] && !bus.i2c_status[0]) && n < 5000) begin
      @(negedge clk40);
      n++;
    end
    if (n >= 5000) fail_now({name, "_done_timeout"});
    repeat (6) @(negedge clk40);
    bus.i2c_start = 1'b0;
    repeat (3) @(negedge clk40);
    chk({name, "_clr_start_pulses"}, clr_cnt, 1);
    chk({name, "_status"}, bus.i2c_status, m_status);
    chk({name, "_bus_sel"}, bus.bus_sel, m_bus);
    chk({name, "_fifo_left"}, wf_q.size(), 0);
    chk({name, "_cmds_missing"}, exp_cmd.size(), 0);
    chk({name, "_rb_missing"}, exp_rb.size(), 0);
    chk({name, "_abort_pulses"}, abort_cnt, 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk40);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.i2c_start = 1'b0;
    bus.i2c_reset = 1'b0;
    bus.rb_full   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk40);
    chk("rst_status", bus.i2c_status, 8'h00);
    chk("rst_go", bus.eng_go, 0);
    chk("rst_rden", bus.wf_rden, 0);
    chk("rst_bus_sel", bus.bus_sel, 0);
    chk("rst_clr_start", bus.i2c_clr_start, 0);
    chk("rst_cmd_tx_mack", {bus.eng_cmd, bus.eng_tx, bus.eng_mack}, 0);
    chk("rst_rb", {bus.rb_we, bus.rb_data, bus.eng_abort}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk40);

    wf_q = '{8'h01, 8'hA0, 8'h02, 8'h55, 8'hAA};
    run_txn("write", 8'h42);

    wf_q = '{8'h02, 8'hA1, 8'h03};
    rx_list = '{8'h11, 8'h22, 8'h33};
    run_txn("read", 8'h82);

    nack_en = 1'b1; nack_byte = 8'hA0;
    wf_q = '{8'h00, 8'hA0, 8'h01, 8'h77, 8'h01, 8'hA0, 8'h00};
    run_txn("addr_nack", 8'h06);
    nack_en = 1'b0;

    wf_q = '{8'h03, 8'hA0, 8'h00};
    run_txn("bad_bus", 8'hD2);

    lat = 4;
    wf_q = '{8'h00, 8'hA0, 8'h03, 8'h11};
    run_txn("underrun", 8'h0A);

    lat = 1;
    wf_q = '{8'h00, 8'h50, 8'h00, 8'h02, 8'hA3, 8'h01};
    rx_list = '{8'h5A};
    run_txn("two_desc", 8'h82);

    // RB_FULL stall, then soft reset while a READ is outstanding.
    lat = 3;
    wf_q = '{8'h02, 8'hA1, 8'h02, 8'h00};
    rx_eng.delete();
    exp_cmd.delete();
    exp_rb.delete();
    push_cmd(C_START, 8'h00, 1'b0);
    push_cmd(C_WRITE, 8'hA1, 1'b0);
    push_cmd(C_READ, 8'h00, 1'b1);
    repeat (3) @(negedge clk40);
    clr_cnt = 0;
    abort_cnt = 0;
    bus.rb_full = 1'b1;
    bus.i2c_start = 1'b1;
    repeat (40) @(negedge clk40);
    chk("stall_read_pending", exp_cmd.size(), 1);
    chk("stall_status_busy", bus.i2c_status, 8'h81);
    lat = 40;
    bus.rb_full = 1'b0;
    n = 0;
    while (exp_cmd.size() != 0 && n < 50) begin
      @(negedge clk40);
      n++;
    end
    if (n >= 50) fail_now("stall_read_issue_timeout");
    repeat (5) @(negedge clk40);
    bus.i2c_reset = 1'b1;
    @(negedge clk40);
    bus.i2c_reset = 1'b0;
    repeat (4) @(negedge clk40);
    chk("reset_abort_pulses", abort_cnt, 1);
    chk("reset_status", bus.i2c_status, 8'h00);
    chk("reset_fifo_untouched", wf_q.size(), 1);
    chk("reset_clr_start_pulses", clr_cnt, 1);
    bus.i2c_start = 1'b0;
    wf_q.delete();
    lat = 2;
    repeat (3) @(negedge clk40);

    wf_q = '{8'h01};
    run_txn("addr_underrun", 8'h4A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
